// File: rtl/mio_bus_responder.sv
// mio_bus_responder: memory/IO end of the CPU MIO bus.
// Decodes one request at a time to data RAM, GPIO or timer registers and
// answers with a one-cycle MIO_ready pulse after a programmable RAM wait.
// Optional feature: define MIO_TIMER_EN to build the timer and INT output;
// without it the timer addresses decode as unmapped and INT is tied low.
module mio_bus_responder #(
    parameter int unsigned RAM_AW   = 10,
    parameter int unsigned RAM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_wr,
    output logic [31:0] Data_rd,
    output logic        MIO_ready,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic        bus_err,
    output logic        INT
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    localparam logic       LP_HAS_WAIT  = (RAM_WAIT != 0);
    localparam logic [3:0] LP_WAIT_INIT = (RAM_WAIT != 0) ? 4'(RAM_WAIT - 1) : 4'd0;

    localparam logic [31:0] ADDR_LED    = 32'hE000_0000;
    localparam logic [31:0] ADDR_SW     = 32'hF000_0000;
    localparam logic [31:0] ADDR_COUNT  = 32'hF000_0004;
    localparam logic [31:0] ADDR_RELOAD = 32'hF000_0008;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [3:0]  r_wcnt;
    logic [31:0] r_data_rd;
    logic [15:0] r_led;
    logic        r_bus_err;
    logic [31:0] r_mem [0:(1 << RAM_AW) - 1];

    logic              w_idle;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic              w_we;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_sel_ram;
    logic              w_sel_led;
    logic              w_sel_sw;
    logic              w_sel_cnt;
    logic              w_sel_rld;
    logic              w_mapped;
    logic              w_commit;
    logic [31:0]       w_rdata;

    // In IDLE the live bus is decoded so single-cycle accesses can commit on
    // the sampling edge; afterwards only the latched request is used.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_addr    = w_idle ? Addr_in : r_addr;
    assign w_wdata   = w_idle ? Data_wr : r_wdata;
    assign w_we      = w_idle ? mem_w   : r_we;
    assign w_ram_idx = w_addr[RAM_AW+1:2];

    assign w_sel_ram = (w_addr[31:RAM_AW+2] == '0);
    assign w_sel_led = (w_addr == ADDR_LED);
    assign w_sel_sw  = (w_addr == ADDR_SW);
`ifdef MIO_TIMER_EN
    assign w_sel_cnt = (w_addr == ADDR_COUNT);
    assign w_sel_rld = (w_addr == ADDR_RELOAD);
`else
    assign w_sel_cnt = 1'b0;
    assign w_sel_rld = 1'b0;
`endif
    assign w_mapped  = w_sel_ram | w_sel_led | w_sel_sw | w_sel_cnt | w_sel_rld;

    // Reset gating keeps a zero-wait RAM write from landing while reset is held.
    assign w_commit  = (w_state_next == ST_READY) && !reset;

    assign MIO_ready = (r_state == ST_READY);
    assign Data_rd   = r_data_rd;
    assign led_out   = r_led;
    assign bus_err   = r_bus_err;

`ifdef MIO_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_reload;
    logic        r_int;

    // Free-running down-counter; a reload write overrides the wrap value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= 32'hFFFF_FFFF;
            r_reload <= 32'hFFFF_FFFF;
            r_int    <= 1'b0;
        end else begin
            r_int <= (r_count == 32'd0);
            if (w_commit && w_we && w_sel_rld) begin
                r_reload <= w_wdata;
                r_count  <= w_wdata;
            end else if (r_count == 32'd0) begin
                r_count <= r_reload;
            end else begin
                r_count <= r_count - 32'd1;
            end
        end
    end

    assign INT = r_int;
`else
    assign INT = 1'b0;
`endif

    // Next-state decode for the IDLE/WAIT/READY handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (CPU_MIO) begin
                    if (w_sel_ram && LP_HAS_WAIT) begin
                        w_state_next = ST_WAIT;
                    end else begin
                        w_state_next = ST_READY;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wcnt == 4'd0) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Read-data mux over the selected target.
    always_comb begin
        w_rdata = 32'd0;
        if (w_sel_ram) begin
            w_rdata = r_mem[w_ram_idx];
        end else if (w_sel_led) begin
            w_rdata = {16'd0, r_led};
        end else if (w_sel_sw) begin
            w_rdata = {16'd0, sw_in};
`ifdef MIO_TIMER_EN
        end else if (w_sel_cnt) begin
            w_rdata = r_count;
        end else if (w_sel_rld) begin
            w_rdata = r_reload;
`endif
        end
    end

    // State register, request latch and wait-state counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
            r_wcnt  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            if (w_idle && CPU_MIO) begin
                r_addr  <= Addr_in;
                r_wdata <= Data_wr;
                r_we    <= mem_w;
                r_wcnt  <= LP_WAIT_INIT;
            end else if (r_state == ST_WAIT && r_wcnt != 4'd0) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
        end
    end

    // Completion side effects: read data, GPIO write and the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_rd <= 32'd0;
            r_led     <= 16'd0;
            r_bus_err <= 1'b0;
        end else if (w_commit) begin
            if (!w_we) begin
                r_data_rd <= w_rdata;
            end
            if (w_we && w_sel_led) begin
                r_led <= w_wdata[15:0];
            end
            if (!w_mapped) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_we && w_sel_ram) begin
            r_mem[w_ram_idx] <= w_wdata;
        end
    end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench for mio_bus_responder: a transaction-level model
// (memory map, latency rule, timer rule) is compared against the DUT every
// cycle, plus literal expectations. Define MIO_TIMER_EN for the timer tests.
module tb_mio_bus_responder;

    localparam int unsigned RAM_AW   = 10;
    localparam int unsigned RAM_WAIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] Addr_in;
    logic [31:0] Data_wr;
    logic [31:0] Data_rd;
    logic        MIO_ready;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic        bus_err;
    logic        INT;

    mio_bus_responder #(
        .RAM_AW   (RAM_AW),
        .RAM_WAIT (RAM_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .CPU_MIO   (CPU_MIO),
        .mem_w     (mem_w),
        .Addr_in   (Addr_in),
        .Data_wr   (Data_wr),
        .Data_rd   (Data_rd),
        .MIO_ready (MIO_ready),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .bus_err   (bus_err),
        .INT       (INT)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    logic [31:0] m_mem [int];
    logic [15:0] m_led;
    logic        m_err;
    logic [31:0] m_rd;
    logic        m_int;
    int          m_rdy_cyc = -1;
    int          int_times[$];
`ifdef MIO_TIMER_EN
    logic [31:0] m_count;
    logic [31:0] m_reload;
    bit          pend = 1'b0;
    int          pend_cyc;
    logic [31:0] pend_val;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_ram(input logic [31:0] a);
        return (a >> (RAM_AW + 2)) == 32'd0;
    endfunction

    function automatic bit is_mapped(input logic [31:0] a);
        if (is_ram(a)) return 1'b1;
        if (a == 32'hE000_0000 || a == 32'hF000_0000) return 1'b1;
`ifdef MIO_TIMER_EN
        if (a == 32'hF000_0004 || a == 32'hF000_0008) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx;
        idx = int'(a[RAM_AW+1:2]);
        if (is_ram(a)) return m_mem.exists(idx) ? m_mem[idx] : 32'd0;
        if (a == 32'hE000_0000) return {16'd0, m_led};
        if (a == 32'hF000_0000) return {16'd0, sw_in};
`ifdef MIO_TIMER_EN
        if (a == 32'hF000_0004) return m_count;
        if (a == 32'hF000_0008) return m_reload;
`endif
        return 32'd0;
    endfunction

    // Per-cycle compare, then advance the timer model to the next cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mio_ready", 32'(MIO_ready), 32'(cyc == m_rdy_cyc));
            chk("led_out", 32'(led_out), 32'(m_led));
            chk("bus_err", 32'(bus_err), 32'(m_err));
            chk("data_rd", Data_rd, m_rd);
            chk("int", 32'(INT), 32'(m_int));
            if (INT) int_times.push_back(cyc);
        end
`ifdef MIO_TIMER_EN
        if (reset) begin
            m_count  = 32'hFFFF_FFFF;
            m_reload = 32'hFFFF_FFFF;
            m_int    = 1'b0;
        end else begin
            m_int = (m_count == 32'd0);
            if (pend && pend_cyc == cyc + 1) begin
                m_reload = pend_val;
                m_count  = pend_val;
                pend     = 1'b0;
            end else if (m_count == 32'd0) begin
                m_count = m_reload;
            end else begin
                m_count = m_count - 32'd1;
            end
        end
`endif
    end

    task automatic do_reset();
        reset     = 1'b1;
        CPU_MIO   = 1'b0;
        m_led     = 16'd0;
        m_err     = 1'b0;
        m_rd      = 32'd0;
        m_int     = 1'b0;
        m_rdy_cyc = -1;
`ifdef MIO_TIMER_EN
        m_count  = 32'hFFFF_FFFF;
        m_reload = 32'hFFFF_FFFF;
        pend     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Request launched after edge k; the DUT samples it on edge k+1.
    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input bit hold, output logic [31:0] rd, output int lat);
        int          k;
        int          exp_lat;
        logic [31:0] exp_rd;
        bit          done;
        done = 1'b0;
        @(posedge clk);
        #1;
        CPU_MIO = 1'b1;
        mem_w   = we;
        Addr_in = a;
        Data_wr = wd;
        k         = cyc;
        exp_lat   = is_ram(a) ? 1 + int'(RAM_WAIT) : 1;
        m_rdy_cyc = k + exp_lat;
        exp_rd    = model_read(a);
`ifdef MIO_TIMER_EN
        if (we && a == 32'hF000_0008) begin
            pend     = 1'b1;
            pend_cyc = k + 1;
            pend_val = wd;
        end
`endif
        lat = -1;
        rd  = 32'd0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            if (MIO_ready) begin
                done = 1'b1;
                lat  = cyc - k;
                rd   = Data_rd;
            end else begin
                // Busy: scramble the bus, the latched request must be used.
                Addr_in = a ^ 32'h0000_0FF0;
                Data_wr = ~wd;
                mem_w   = ~we;
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        if (!we) chk("read_data", rd, exp_rd);
        if (!is_mapped(a)) m_err = 1'b1;
        if (we) begin
            if (is_ram(a)) m_mem[int'(a[RAM_AW+1:2])] = wd;
            else if (a == 32'hE000_0000) m_led = wd[15:0];
        end else begin
            m_rd = exp_rd;
        end
        if (!done) m_rdy_cyc = -1;
        if (!hold || !done) CPU_MIO = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          wcyc;
        reset   = 1'b1;
        CPU_MIO = 1'b0;
        mem_w   = 1'b0;
        Addr_in = 32'd0;
        Data_wr = 32'd0;
        sw_in   = 16'h1234;
        do_reset();
        chk_en = 1'b1;

        // 1: idle after reset
        repeat (5) @(posedge clk);
        #1;
        chk("rst_ready", 32'(MIO_ready), 32'd0);
        chk("rst_led", 32'(led_out), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_data_rd", Data_rd, 32'd0);

        // 2: RAM write/read, 3-cycle latency
        access(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b0, rd, lat);
        chk("ram_wr_lat", 32'(lat), 32'd3);
        access(1'b0, 32'h0000_0010, 32'd0, 1'b0, rd, lat);
        chk("ram_rd_lat", 32'(lat), 32'd3);
        chk("ram_rd_data", rd, 32'hCAFE_F00D);
        access(1'b0, 32'h0000_0013, 32'd0, 1'b0, rd, lat);
        chk("ram_byte_ofs", rd, 32'hCAFE_F00D);

        // Back-to-back with CPU_MIO held through the ready cycle
        access(1'b1, 32'h0000_001C, 32'h1234_5678, 1'b1, rd, lat);
        access(1'b0, 32'h0000_001C, 32'd0, 1'b0, rd, lat);
        chk("b2b_data", rd, 32'h1234_5678);

        // 3: GPIO write, switch read, writes to switches ignored
        access(1'b1, 32'hE000_0000, 32'h0000_A5A5, 1'b0, rd, lat);
        chk("led_lat", 32'(lat), 32'd1);
        chk("led_val", 32'(led_out), 32'h0000_A5A5);
        access(1'b1, 32'hF000_0000, 32'h0000_FFFF, 1'b0, rd, lat);
        access(1'b0, 32'hF000_0000, 32'd0, 1'b0, rd, lat);
        chk("sw_data", rd, 32'h0000_1234);
        chk("sw_no_err", 32'(bus_err), 32'd0);
        access(1'b0, 32'hE000_0000, 32'd0, 1'b0, rd, lat);
        chk("led_rd", rd, 32'h0000_A5A5);

        // 4: unmapped accesses
        access(1'b1, 32'h8000_0000, 32'h5555_5555, 1'b0, rd, lat);
        chk("unm_wr_err", 32'(bus_err), 32'd1);
        access(1'b0, 32'h8000_0000, 32'd0, 1'b0, rd, lat);
        chk("unm_rd_lat", 32'(lat), 32'd1);
        chk("unm_rd_data", rd, 32'd0);
        chk("unm_err_sticky", 32'(bus_err), 32'd1);

        // 6: reset during the WAIT of a RAM write
        access(1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, rd, lat);
        @(posedge clk);
        #1;
        CPU_MIO = 1'b1;
        mem_w   = 1'b1;
        Addr_in = 32'h0000_0020;
        Data_wr = 32'h2222_2222;
        @(posedge clk);
        #1;
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_err", 32'(bus_err), 32'd0);
        chk("post_rst_led", 32'(led_out), 32'd0);
        access(1'b0, 32'h0000_0020, 32'd0, 1'b0, rd, lat);
        chk("rst_wr_dropped", rd, 32'h1111_1111);

`ifdef MIO_TIMER_EN
        // 5: reload=3 gives INT every 4 cycles
        access(1'b1, 32'hF000_0008, 32'd3, 1'b0, rd, lat);
        int_times.delete();
        repeat (14) @(posedge clk);
        #1;
        if (int_times.size() >= 2) chk("int_period", 32'(int_times[1] - int_times[0]), 32'd4);
        else chk("int_seen", 32'(int_times.size()), 32'd2);
        // Reload write landing on the edge where count is 0
        for (int i = 0; i < 10; i++) begin
            if (m_count == 32'd1) break;
            @(posedge clk);
            #1;
        end
        int_times.delete();
        access(1'b1, 32'hF000_0008, 32'd7, 1'b0, rd, lat);
        wcyc = cyc;
        chk("int_on_reload", 32'(INT), 32'd1);
        access(1'b0, 32'hF000_0004, 32'd0, 1'b0, rd, lat);
        chk("count_after_reload", rd, 32'd6);
        for (int i = 0; i < 20 && int_times.size() < 2; i++) @(posedge clk);
        #1;
        if (int_times.size() >= 2) begin
            chk("int_first", 32'(int_times[0]), 32'(wcyc));
            chk("int_next", 32'(int_times[1] - wcyc), 32'd8);
        end else begin
            chk("int_seen2", 32'(int_times.size()), 32'd2);
        end
`else
        // Timer addresses decode as unmapped in this build
        access(1'b0, 32'hF000_0004, 32'd0, 1'b0, rd, lat);
        chk("notimer_rd", rd, 32'd0);
        chk("notimer_err", 32'(bus_err), 32'd1);
        access(1'b1, 32'hF000_0008, 32'd3, 1'b0, rd, lat);
        repeat (10) @(posedge clk);
        #1;
        chk("notimer_int", 32'(int_times.size()), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
